mem_read_responder: RTL and testbench

MEM_READ_RESPONDER -- requirements
Module: mem_read_responder

---
 rtl/mem_read_pkg.sv | 12 +
 rtl/mem_read_rf.sv | 29 ++
 rtl/mem_read_responder.sv | 99 +++++++++
 tb/tb_mem_read_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_pkg.sv
// Shared types for the memory read responder: transfer FSM states and the wait-count type.
package mem_read_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef logic [3:0] wcnt_t;

endpackage

// File: rtl/mem_read_rf.sv
// Register file: one synchronous write port, one asynchronous read port, cleared on reset.
module mem_read_rf #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_read_responder.sv
// Read responder: latches a request, stretches it with N wait states, returns data from the
// local register file and tracks completed transfers and protocol errors.
module mem_read_responder
  import mem_read_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          ds,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    wait_cfg,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic          ws,
  output logic [DW-1:0] rdata,
  output logic          rdata_vld,
  output logic          err,
  output logic [7:0]    xfer_cnt
);

  state_e        state_q, state_d;
  wcnt_t         cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic [7:0]    xfer_cnt_q, xfer_cnt_d;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rf_rdata;

  mem_read_rf #(.AW(AW), .DW(DW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addr_q),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      xfer_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      xfer_cnt_q <= xfer_cnt_d;
      if (rdata_vld) rdata_q <= rf_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    err_d      = err_q;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // ds outside a transfer is a protocol error and blocks a same-cycle start
        if (ds) begin
          err_d = 1'b1;
        end else if (rd) begin
          addr_d  = addr;
          cnt_d   = wait_cfg;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (ds || !rd) begin
          // rd+ds together or neither (abort) are both errors; either way the transfer counts
          if (rd == ds) err_d = 1'b1;
          state_d    = ST_FINISH;
          xfer_cnt_d = xfer_cnt_q + 8'd1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - wcnt_t'(1);
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign ws        = (state_q == ST_ACCESS) && (cnt_q != '0);
  assign rdata_vld = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign rdata     = rdata_vld ? rf_rdata : rdata_q;
  assign err       = err_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder with a transfer-level reference model checked every cycle.
module tb_mem_read_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd = 1'b0, ds = 1'b0, we = 1'b0;
  logic [3:0] addr = '0, wait_cfg = '0, waddr = '0;
  logic [7:0] wdata = '0;
  logic       ws, rdata_vld, err;
  logic [7:0] rdata, xfer_cnt;

  int n_chk = 0;
  int n_err = 0;

  mem_read_responder #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .rd(rd), .ds(ds), .addr(addr), .wait_cfg(wait_cfg),
    .we(we), .waddr(waddr), .wdata(wdata), .ws(ws), .rdata(rdata),
    .rdata_vld(rdata_vld), .err(err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 = no transfer, 1 = transfer open, 2 = closing cycle.
  int         m_ph;
  int         m_left;
  int         m_addr;
  int         m_cnt;
  bit         m_err;
  logic [7:0] m_mem [16];
  logic [7:0] m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   <= 0;
      m_left <= 0;
      m_addr <= 0;
      m_cnt  <= 0;
      m_err  <= 1'b0;
      m_last <= 8'h00;
      for (int i = 0; i < 16; i++) m_mem[i] <= 8'h00;
    end else begin
      if (m_ph == 1 && m_left == 0) m_last <= m_mem[m_addr];
      if (m_ph == 0) begin
        if (ds) m_err <= 1'b1;
        else if (rd) begin
          m_addr <= int'(addr);
          m_left <= int'(wait_cfg);
          m_ph   <= 1;
        end
      end else if (m_ph == 1) begin
        if (ds || !rd) begin
          if ((rd && ds) || (!rd && !ds)) m_err <= 1'b1;
          m_ph  <= 2;
          m_cnt <= (m_cnt + 1) % 256;
        end else if (m_left > 0) begin
          m_left <= m_left - 1;
        end
      end else begin
        m_ph <= 0;
      end
      if (we) m_mem[waddr] <= wdata;
    end
  end

  always @(negedge clk) begin
    logic       e_vld, e_ws;
    logic [7:0] e_rd;
    e_vld = (m_ph == 1) && (m_left == 0);
    e_ws  = (m_ph == 1) && (m_left != 0);
    e_rd  = e_vld ? m_mem[m_addr] : m_last;
    chk("model_ws", ws, e_ws);
    chk("model_vld", rdata_vld, e_vld);
    chk("model_rdata", rdata, e_rd);
    chk("model_err", err, m_err);
    chk("model_xfer_cnt", xfer_cnt, m_cnt[7:0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_reset();
    rd = 1'b0; ds = 1'b0; we = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Full transfer: start, hold rd through wait states, then ds; rd=1 during FINISH must be ignored.
  task automatic xfer(input logic [3:0] a, input logic [3:0] n, input logic [7:0] expd,
                      output int wsc);
    int guard;
    rd = 1'b1; addr = a; wait_cfg = n;
    tick();
    wsc = 0; guard = 0;
    while (ws === 1'b1 && guard < 40) begin
      wsc++; guard++;
      tick();
    end
    if (guard >= 40) chk("ws_timeout", 1, 0);
    chk("xfer_vld", rdata_vld, 1);
    chk("xfer_rdata", rdata, expd);
    rd = 1'b0; ds = 1'b1;
    tick();
    ds = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("finish_ignores_rd", rdata_vld, 0);
  endtask

  initial begin
    int wsc;
    #1 rst = 1'b1;
    #2;
    chk("rst_ws", ws, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_vld", rdata_vld, 0);
    chk("rst_err", err, 0);
    chk("rst_xfer", xfer_cnt, 8'd0);
    tick();
    tick();
    rst = 1'b0;

    // N=0 transfer
    wr(4'd3, 8'hA5);
    xfer(4'd3, 4'd0, 8'hA5, wsc);
    chk("n0_ws_cycles", wsc, 0);
    chk("n0_xfer", xfer_cnt, 8'd1);
    chk("n0_err", err, 0);

    // N=3 transfer
    wr(4'd7, 8'h3C);
    xfer(4'd7, 4'd3, 8'h3C, wsc);
    chk("n3_ws_cycles", wsc, 3);
    chk("n3_xfer", xfer_cnt, 8'd2);
    chk("n3_err", err, 0);

    // Write to addr_q during ACCESS, then rdata holds after the transfer
    wr(4'd5, 8'h11);
    rd = 1'b1; addr = 4'd5; wait_cfg = 4'd0;
    tick();
    chk("wacc_old", rdata, 8'h11);
    we = 1'b1; waddr = 4'd5; wdata = 8'h5A;
    tick();
    we = 1'b0;
    chk("wacc_new", rdata, 8'h5A);
    chk("wacc_vld", rdata_vld, 1);
    rd = 1'b0; ds = 1'b1;
    tick();
    ds = 1'b0;
    tick();
    chk("hold_rdata", rdata, 8'h5A);
    chk("wacc_xfer", xfer_cnt, 8'd3);

    // Abort: rd drops without ds
    rd = 1'b1; addr = 4'd2; wait_cfg = 4'd2;
    tick();
    chk("abort_ws", ws, 1);
    rd = 1'b0;
    tick();
    chk("abort_err", err, 1);
    chk("abort_xfer", xfer_cnt, 8'd4);
    chk("abort_ws_fin", ws, 0);
    tick();

    // Reset while ws is high
    rd = 1'b1; addr = 4'd3; wait_cfg = 4'd5;
    tick();
    tick();
    chk("rstmid_ws_before", ws, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_ws", ws, 0);
    chk("rstmid_rdata", rdata, 8'h00);
    chk("rstmid_xfer", xfer_cnt, 8'd0);
    chk("rstmid_err", err, 0);
    rd = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    xfer(4'd3, 4'd0, 8'h00, wsc);
    chk("post_rst_xfer", xfer_cnt, 8'd1);
    chk("post_rst_err", err, 0);

    // ds while idle
    ds = 1'b1;
    tick();
    ds = 1'b0;
    chk("ds_idle_err", err, 1);
    chk("ds_idle_xfer", xfer_cnt, 8'd1);
    chk("ds_idle_vld", rdata_vld, 0);
    tick();

    // rd and ds together in ACCESS
    do_reset();
    rd = 1'b1; addr = 4'd7; wait_cfg = 4'd0;
    tick();
    ds = 1'b1;
    tick();
    rd = 1'b0; ds = 1'b0;
    chk("rdds_err", err, 1);
    chk("rdds_xfer", xfer_cnt, 8'd1);
    chk("rdds_vld", rdata_vld, 0);
    tick();

    // 256 back-to-back transfers wrap the counter
    do_reset();
    wr(4'd1, 8'hC3);
    for (int i = 0; i < 256; i++) begin
      xfer(4'd1, 4'd0, 8'hC3, wsc);
      if (i == 254) chk("wrap_255", xfer_cnt, 8'd255);
    end
    chk("wrap_0", xfer_cnt, 8'd0);
    chk("wrap_err", err, 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
